// File: rtl/isa_master_pkg.sv
// Shared types and timing defaults for the ISA 8-bit I/O cycle master.
package isa_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_RDY,
    HOLD
  } state_e;

  localparam int unsigned DEF_SETUP_CYCLES  = 2;
  localparam int unsigned DEF_STROBE_CYCLES = 10;
  localparam int unsigned DEF_HOLD_CYCLES   = 2;
  localparam int unsigned DEF_READY_TIMEOUT = 1000;
  localparam int unsigned DEF_TO_CNT_W      = $clog2(DEF_READY_TIMEOUT + 1);

  // The phase counter is shared by every state, so it must hold the largest reload.
  function automatic int unsigned cnt_width(input int unsigned setup_c, input int unsigned strobe_c,
                                            input int unsigned hold_c, input int unsigned timeout_c);
    int unsigned m;
    m = setup_c;
    if (strobe_c > m) m = strobe_c;
    if (hold_c > m) m = hold_c;
    if (timeout_c > m) m = timeout_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_io_cycle_master.sv
// Runs one 8-bit ISA I/O read or write per start pulse, owning strobe timing and IOCHRDY waits.
// Handshake: start is sampled only in IDLE; busy is high for the whole cycle and done pulses once on return to IDLE.
module isa_io_cycle_master
  import isa_master_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned READY_TIMEOUT = DEF_READY_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata,
  output logic [15:0] isa_sa,
  output logic [7:0]  isa_sd_out,
  output logic        isa_sd_oe,
  input  logic [7:0]  isa_sd_in,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic        isa_aen,
  input  logic        isa_iochrdy
);

  localparam int unsigned CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, READY_TIMEOUT);

  localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(READY_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [15:0]   sa_q, sa_d;
  logic [7:0]    sd_out_q, sd_out_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aen_q, aen_d;
  logic          oe_q, oe_d;
  logic          ior_n_q, ior_n_d;
  logic          iow_n_q, iow_n_d;
  logic          strobe_d;
  logic          rdy_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rdy_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (isa_iochrdy),
    .q_o   (rdy_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    sa_d      = sa_q;
    sd_out_d  = sd_out_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d      = rw;
          sa_d      = addr;
          sd_out_d  = wdata;
          timeout_d = 1'b0;
          cnt_d     = SETUP_LOAD;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LOAD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rdy_s) begin
          if (rw_q) rdata_d = isa_sd_in;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          if (rw_q) rdata_d = isa_sd_in;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          // Card never became ready: flag it and return all-ones like an empty bus.
          timeout_d = 1'b1;
          if (rw_q) rdata_d = 8'hFF;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin controls are registered from the next state so the ISA strobes never glitch.
  always_comb begin
    strobe_d = (state_d == STROBE) || (state_d == WAIT_RDY);
    busy_d   = (state_d != IDLE);
    aen_d    = !busy_d;
    oe_d     = busy_d && !rw_d;
    ior_n_d  = !(strobe_d && rw_d);
    iow_n_d  = !(strobe_d && !rw_d);
    done_d   = (state_q == HOLD) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      sa_q      <= 16'h0000;
      sd_out_q  <= 8'h00;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aen_q     <= 1'b1;
      oe_q      <= 1'b0;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      sa_q      <= sa_d;
      sd_out_q  <= sd_out_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aen_q     <= aen_d;
      oe_q      <= oe_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign rdata      = rdata_q;
  assign isa_sa     = sa_q;
  assign isa_sd_out = sd_out_q;
  assign isa_sd_oe  = oe_q;
  assign isa_ior_n  = ior_n_q;
  assign isa_iow_n  = iow_n_q;
  assign isa_aen    = aen_q;

endmodule

// File: tb/tb_isa_io_cycle_master.sv
// Directed bench for isa_io_cycle_master: writes, reads, wait states, timeout, back-to-back and mid-cycle reset.
module tb_isa_io_cycle_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  isa_sd_in = 8'h00;
  logic        isa_iochrdy = 1'b1;
  logic        busy, done, timeout, isa_sd_oe, isa_ior_n, isa_iow_n, isa_aen;
  logic [7:0]  rdata, isa_sd_out;
  logic [15:0] isa_sa;

  int pass_cnt = 0;
  int total_cnt = 0;

  int   m_busy, m_iow, m_ior, m_first, m_last, m_done_c;
  int   m_oe_bad, m_sa_bad, m_sd_bad, m_aen_bad, m_both;
  logic m_to_c1;
  int   n_done;

  isa_io_cycle_master dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .rdata       (rdata),
    .isa_sa      (isa_sa),
    .isa_sd_out  (isa_sd_out),
    .isa_sd_oe   (isa_sd_oe),
    .isa_sd_in   (isa_sd_in),
    .isa_ior_n   (isa_ior_n),
    .isa_iow_n   (isa_iow_n),
    .isa_aen     (isa_aen),
    .isa_iochrdy (isa_iochrdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one start and watches every cycle until done (bounded); iochrdy is low for cycles [lo_from, lo_to).
  task automatic measure(input logic r, input logic [15:0] a, input logic [7:0] d,
                         input int lo_from, input int lo_to, input int mid_c,
                         input logic [7:0] sd_before, input logic [7:0] sd_after);
    m_busy = 0; m_iow = 0; m_ior = 0; m_first = 0; m_last = 0; m_done_c = 0;
    m_oe_bad = 0; m_sa_bad = 0; m_sd_bad = 0; m_aen_bad = 0; m_both = 0; m_to_c1 = 1'bx;
    rw = r; addr = a; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      isa_iochrdy = !(c >= lo_from && c < lo_to);
      isa_sd_in = (c < lo_to) ? sd_before : sd_after;
      start = (c == mid_c);
      if (c == mid_c) begin
        rw = !r; addr = 16'hBEEF; wdata = 8'h5C;
      end
      if (c == 1) m_to_c1 = timeout;
      if (done) begin
        m_done_c = c;
        break;
      end
      if (busy) m_busy++;
      if (!isa_iow_n || !isa_ior_n) begin
        if (m_first == 0) m_first = c;
        m_last = c;
      end
      if (!isa_iow_n) m_iow++;
      if (!isa_ior_n) m_ior++;
      if (!isa_iow_n && !isa_ior_n) m_both++;
      if (busy && (isa_sd_oe !== !r)) m_oe_bad++;
      if (busy && (isa_sa !== a)) m_sa_bad++;
      if (busy && !r && (isa_sd_out !== d)) m_sd_bad++;
      if (busy && (isa_aen !== 1'b0)) m_aen_bad++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string p, input int exp_busy, input int exp_strobe, input logic r);
    chk({p, "_done_at"}, m_done_c, exp_busy + 1);
    chk({p, "_busy_clks"}, m_busy, exp_busy);
    chk({p, "_strobe_first"}, m_first, 3);
    chk({p, "_strobe_last"}, m_last, 2 + exp_strobe);
    chk({p, "_iow_clks"}, m_iow, r ? 0 : exp_strobe);
    chk({p, "_ior_clks"}, m_ior, r ? exp_strobe : 0);
    chk({p, "_both_low"}, m_both, 0);
    chk({p, "_oe_bad"}, m_oe_bad, 0);
    chk({p, "_sa_bad"}, m_sa_bad, 0);
    chk({p, "_sd_bad"}, m_sd_bad, 0);
    chk({p, "_aen_bad"}, m_aen_bad, 0);
    chk({p, "_end_busy"}, busy, 0);
    chk({p, "_end_aen"}, isa_aen, 1);
    chk({p, "_end_oe"}, isa_sd_oe, 0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_oe", isa_sd_oe, 0);
    chk("rst_ior", isa_ior_n, 1);
    chk("rst_iow", isa_iow_n, 1);
    chk("rst_aen", isa_aen, 1);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_sa", isa_sa, 16'h0000);
    chk("rst_sd_out", isa_sd_out, 8'h00);

    // Plain write
    measure(1'b0, 16'h0220, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    check_result("wr", 14, 10, 1'b0);
    chk("wr_rdata", rdata, 8'h00);
    chk("wr_timeout", timeout, 0);
    tick();
    chk("wr_done_once", done, 0);

    // Plain read
    measure(1'b1, 16'h022A, 8'h00, 0, 0, 0, 8'h00, 8'h3C);
    check_result("rd", 14, 10, 1'b1);
    chk("rd_rdata", rdata, 8'h3C);
    chk("rd_timeout", timeout, 0);

    // Read with 14 wait clocks: IOCHRDY low strobe clocks 2..21, data changes as ready returns
    measure(1'b1, 16'h0388, 8'h00, 4, 24, 0, 8'hEE, 8'h5A);
    check_result("ws", 28, 24, 1'b1);
    chk("ws_rdata", rdata, 8'h5A);
    chk("ws_timeout", timeout, 0);
    tick();

    // IOCHRDY stuck low: 1000 wait clocks then abort
    measure(1'b1, 16'h0300, 8'h00, 1, 100000, 0, 8'h42, 8'h42);
    check_result("to", 1014, 1010, 1'b1);
    chk("to_flag", timeout, 1);
    chk("to_rdata", rdata, 8'hFF);
    tick();
    chk("to_sticky", timeout, 1);

    // Next start clears timeout; a start mid-cycle is ignored; write keeps rdata
    measure(1'b0, 16'h0220, 8'h11, 0, 0, 5, 8'h00, 8'h00);
    chk("clr_to_c1", m_to_c1, 0);
    check_result("mid", 14, 10, 1'b0);
    chk("mid_rdata", rdata, 8'hFF);

    // Back-to-back: each start lands in the clock where done is high
    measure(1'b1, 16'h022A, 8'h00, 0, 0, 0, 8'h00, 8'h77);
    check_result("b2b_rd", 14, 10, 1'b1);
    chk("b2b_rd_rdata", rdata, 8'h77);
    measure(1'b0, 16'h0221, 8'hC3, 0, 0, 0, 8'h00, 8'h00);
    check_result("b2b_wr", 14, 10, 1'b0);
    chk("b2b_wr_rdata", rdata, 8'h77);
    tick();

    // Reset in the middle of a write strobe
    rw = 1'b0; addr = 16'h02F0; wdata = 8'h3E; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mr_pre_iow", isa_iow_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("mr_iow", isa_iow_n, 1);
    chk("mr_ior", isa_ior_n, 1);
    chk("mr_aen", isa_aen, 1);
    chk("mr_oe", isa_sd_oe, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    tick();
    tick();
    reset = 1'b0;
    n_done = 0;
    repeat (20) begin
      tick();
      if (done || busy) n_done++;
    end
    chk("mr_no_done", n_done, 0);
    measure(1'b0, 16'h0222, 8'h96, 0, 0, 0, 8'h00, 8'h00);
    check_result("post_rst", 14, 10, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/isa_io_cycle_master.md
Name: isa_io_cycle_master

Overview:
- Executes one 8-bit ISA I/O read or write cycle on the CT2960 card slot per request.
- Requests come from the HPS-side register file (address register, data register, control register).
- Read data goes back into the "data from card" register.
- Sits between the Qsys register file and the ISA connector pins; owns all bus strobe timing and IOCHRDY wait-state handling.

Parameters:
- SETUP_CYCLES, 2: clocks address/AEN/write data are stable before the strobe asserts (>=1).
- STROBE_CYCLES, 10: minimum clocks IOR_n/IOW_n are held low (>=3).
- HOLD_CYCLES, 2: clocks address/data are held after the strobe rises (>=1).
- READY_TIMEOUT, 1000: maximum extra clocks waiting for IOCHRDY before the cycle is aborted (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse; accepted only in IDLE
- rw  in  1  1 = I/O read, 0 = I/O write (captured on start)
- addr  in  16  I/O address (captured on start)
- wdata  in  8  write data (captured on start)
- busy  out  1  high while a cycle is in progress
- done  out  1  one-clock pulse at cycle completion
- timeout  out  1  sticky; set when IOCHRDY timed out, cleared by the next accepted start
- rdata  out  8  read data, valid from done until the next read completes
- isa_sa  out  16  ISA address bus
- isa_sd_out  out  8  ISA data bus drive value
- isa_sd_oe  out  1  data bus output enable
- isa_sd_in  in  8  ISA data bus sampled value
- isa_ior_n  out  1  I/O read strobe, active low
- isa_iow_n  out  1  I/O write strobe, active low
- isa_aen  out  1  address enable; high = bus not owned by an I/O cycle
- isa_iochrdy  in  1  card ready, asynchronous, low = insert wait states

Behaviour:
- Reset values:
  - busy, done, timeout, isa_sd_oe = 0
  - isa_ior_n, isa_iow_n, isa_aen = 1
  - rdata = 8'h00, isa_sa = 16'h0000, isa_sd_out = 8'h00
  - state = IDLE
- IOCHRDY passes through a 2-flop synchronizer (rdy_s) before use.
- FSM states: IDLE, SETUP, STROBE, WAIT_RDY, HOLD. A single down-counter is reloaded on each state entry.
- IDLE:
  - start=1 captures rw/addr/wdata, clears timeout, and goes to SETUP.
  - From the next cycle: busy=1, isa_aen=0, isa_sa=addr; for writes, isa_sd_oe=1 and isa_sd_out=wdata.
- SETUP: lasts SETUP_CYCLES, then goes to STROBE.
- STROBE:
  - The selected strobe (ior_n for reads, iow_n for writes) is low for STROBE_CYCLES.
  - On the last cycle: if rdy_s=1, latch isa_sd_in into rdata (reads) and go to HOLD; otherwise go to WAIT_RDY.
  - Because of synchronizer latency, the card must drop IOCHRDY within the first STROBE_CYCLES-2 strobe clocks.
- WAIT_RDY:
  - The strobe stays low.
  - rdy_s=1: latch rdata (reads) and go to HOLD.
  - After READY_TIMEOUT clocks without ready: set timeout, rdata=8'hFF for reads, go to HOLD.
- HOLD: strobe high; address, AEN and write data held for HOLD_CYCLES, then go to IDLE.
- IDLE entry: done=1 for exactly one clock; busy=0, isa_aen=1, isa_sd_oe=0 in that same clock.
- Latency without waits: busy is high for SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES clocks; done is high in the following clock.
- start while busy is ignored, with no queueing. start in the same clock done is high is accepted.
- Writes leave rdata unchanged.
- Reset mid-cycle: strobes deassert, AEN returns high and the data bus is released asynchronously; no done pulse is generated.
- Strobes are never both low; the strobe is never low in SETUP, HOLD or IDLE.

Decomposition:
- Package isa_master_pkg: state enum, default timing constants, timeout counter width ($clog2(READY_TIMEOUT+1)).
- Sub-module sync_2ff: parameterised 2-flop synchronizer with async active-high reset, reset value 1 for IOCHRDY.

Test Plan:
- Write, no waits: start rw=0 addr=16'h0220 wdata=8'hA5, IOCHRDY=1 -> iow_n low exactly 10 clocks starting 3 clocks after start; isa_sa=0220 and sd_out=A5 with oe=1 for 14 busy clocks; done pulses once; ior_n stays 1.
- Read, no waits: start rw=1 addr=16'h022A, sd_in=8'h3C -> ior_n low 10 clocks, oe=0 throughout, rdata=3C at done, timeout=0.
- Wait states: read of 0x0388, IOCHRDY low from strobe clock 2 and high 20 clocks later -> strobe extended, rdata sampled after ready, busy = 14 + wait clocks, timeout=0.
- Timeout: IOCHRDY held low permanently on read -> after READY_TIMEOUT clocks timeout=1, rdata=FF, done pulses; the next start clears timeout.
- Start while busy and back-to-back: second start mid-cycle ignored; start coincident with done accepted, with a fresh SETUP phase.
- Reset during STROBE of a write -> iow_n=1, aen=1, oe=0 immediately; busy=0; no done pulse; next start runs normally.
